// File: rtl/nbr_ctrl.sv
// nbr_ctrl: sequencing controller for the NBR32 bistable-ring PUF macro.
// Accepts a challenge, runs NEVAL reset/settle/sample evaluations of it on the ring,
// majority-votes the sampled ring output and returns the voted bit plus the ones-count.
//
// Ports
//   CLK, RESET               clock, synchronous active-high reset
//   REQ_VALID/READY/CHAL     challenge request handshake
//   RESP_VALID/READY         response handshake
//   RESP_BIT, RESP_ONES      voted bit and number of evaluations that sampled 1
//   BUSY                     transaction in progress
//   PUF_RESET, PUF_C         drive the ring RESET and C pins
//   PUF_OUT                  ring output, asynchronous to CLK
module nbr_ctrl #(
  parameter int unsigned CW         = 32,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned NEVAL      = 7,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [CW-1:0]    REQ_CHAL,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic             RESP_BIT,
  output logic [CNT_W-1:0] RESP_ONES,
  output logic             BUSY,
  output logic             PUF_RESET,
  output logic [CW-1:0]    PUF_C,
  input  logic             PUF_OUT
);

  localparam int unsigned PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] eval_q, eval_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] resp_ones_q, resp_ones_d;
  logic [CW-1:0]    chal_q, chal_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_bit_q, resp_bit_d;
  logic             busy_q, busy_d;
  logic             puf_reset_q, puf_reset_d;

  logic [1:0]       sync_q;
  logic             out_s;
  logic [CNT_W-1:0] eval_inc;
  logic [CNT_W:0]   twice_ones;

  // Two-flop synchronizer: the only path from the ring output into logic.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], PUF_OUT};
    end
  end

  assign out_s = sync_q[1];

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      resp_ones_q  <= '0;
      chal_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
      puf_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      resp_ones_q  <= resp_ones_d;
      chal_q       <= chal_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_bit_q   <= resp_bit_d;
      busy_q       <= busy_d;
      puf_reset_q  <= puf_reset_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    resp_ones_d  = resp_ones_q;
    chal_d       = chal_q;
    resp_valid_d = resp_valid_q;
    resp_bit_d   = resp_bit_q;
    eval_inc     = eval_q + CNT_W'(1);
    // Majority test done one bit wider so 2*ones cannot wrap.
    twice_ones   = {ones_q, 1'b0};

    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          chal_d  = REQ_CHAL;
          ones_d  = '0;
          eval_d  = '0;
          ph_d    = '0;
          state_d = S_RST;
        end
      end
      S_RST: begin
        if (ph_q == PH_W'(RST_CYC - 1)) begin
          ph_d    = '0;
          state_d = S_SETTLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
          ph_d    = '0;
          state_d = S_SAMPLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SAMPLE: begin
        ones_d  = ones_q + CNT_W'(out_s);
        eval_d  = eval_inc;
        state_d = (eval_inc == CNT_W'(NEVAL)) ? S_DONE : S_RST;
      end
      S_DONE: begin
        // First DONE cycle captures the result; valid rises on the following edge.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_ones_d  = ones_q;
          resp_bit_d   = (twice_ones > (CNT_W + 1)'(NEVAL));
        end else if (RESP_READY) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs track the state being entered so they line up with it.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    puf_reset_d = !((state_d == S_SETTLE) || (state_d == S_SAMPLE));
  end

  assign REQ_READY  = req_ready_q;
  assign RESP_VALID = resp_valid_q;
  assign RESP_BIT   = resp_bit_q;
  assign RESP_ONES  = resp_ones_q;
  assign BUSY       = busy_q;
  assign PUF_RESET  = puf_reset_q;
  assign PUF_C      = chal_q;

endmodule

// File: tb/tb_nbr_ctrl.sv
// tb_nbr_ctrl: self-checking bench for nbr_ctrl. A transaction-level model predicts
// every registered output each cycle; directed tests pin the model with literal values.
module tb_nbr_ctrl;

  localparam int unsigned CW         = 32;
  localparam int unsigned RST_CYC    = 4;
  localparam int unsigned SETTLE_CYC = 64;
  localparam int unsigned NEVAL      = 7;
  localparam int unsigned CNT_W      = 8;
  localparam int          E          = RST_CYC + SETTLE_CYC + 1;
  localparam int          LAT        = NEVAL * E + 1;

  logic             clk;
  logic             rst;
  logic             req_valid, req_ready;
  logic [CW-1:0]    req_chal;
  logic             resp_valid, resp_ready, resp_bit;
  logic [CNT_W-1:0] resp_ones;
  logic             busy, puf_reset, puf_out;
  logic [CW-1:0]    puf_c;

  logic             req_valid2, req_ready2, resp_valid2, resp_ready2, resp_bit2;
  logic [CNT_W-1:0] resp_ones2;
  logic             busy2, puf_reset2, puf_out2;
  logic [CW-1:0]    puf_c2;

  nbr_ctrl #(.CW(CW), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .NEVAL(NEVAL), .CNT_W(CNT_W)) u_dut (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_CHAL(req_chal),
    .RESP_VALID(resp_valid), .RESP_READY(resp_ready), .RESP_BIT(resp_bit), .RESP_ONES(resp_ones),
    .BUSY(busy), .PUF_RESET(puf_reset), .PUF_C(puf_c), .PUF_OUT(puf_out)
  );

  nbr_ctrl #(.CW(CW), .RST_CYC(1), .SETTLE_CYC(2), .NEVAL(1), .CNT_W(CNT_W)) u_dut_s (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid2), .REQ_READY(req_ready2), .REQ_CHAL(req_chal),
    .RESP_VALID(resp_valid2), .RESP_READY(resp_ready2), .RESP_BIT(resp_bit2), .RESP_ONES(resp_ones2),
    .BUSY(busy2), .PUF_RESET(puf_reset2), .PUF_C(puf_c2), .PUF_OUT(puf_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle-time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          cyc = 0;
  int          t0 = 0;
  bit          m_known = 0;
  bit          m_active, m_ready, m_valid, m_bit, m_busy, m_prst;
  int          m_t, m_ones, m_resp_ones;
  logic [CW-1:0] m_c;
  bit          pv1, pv2;   // ring output seen one and two edges ago

  always @(posedge clk) begin : model
    bit samp;
    cyc++;
    if (rst) begin
      m_known = 1; m_active = 0; m_ready = 0; m_valid = 0; m_bit = 0; m_busy = 0;
      m_prst = 1; m_c = '0; m_t = 0; m_ones = 0; m_resp_ones = 0; pv1 = 0; pv2 = 0;
    end else begin
      samp = pv2; pv2 = pv1; pv1 = puf_out;
      if (!m_active) begin
        if (req_valid && m_ready) begin
          m_active = 1; m_t = 0; m_c = req_chal; m_ones = 0;
        end
      end else if (m_valid) begin
        if (resp_ready) begin
          m_active = 0; m_valid = 0;
        end
      end else begin
        m_t++;
        // Each evaluation ends with a sample every E cycles after the accept.
        if (m_t % E == 0) m_ones += int'(samp);
        if (m_t == LAT) begin
          m_valid = 1; m_resp_ones = m_ones; m_bit = (2 * m_ones > int'(NEVAL));
        end
      end
      m_ready = !m_active;
      m_busy  = m_active;
      m_prst  = !m_active || (m_t >= int'(NEVAL) * E) || ((m_t % E) < int'(RST_CYC));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int low_cnt = 0;
  always @(negedge clk) begin
    if (m_known) begin
      chk("req_ready",  64'(req_ready),  64'(m_ready));
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      chk("busy",       64'(busy),       64'(m_busy));
      chk("puf_reset",  64'(puf_reset),  64'(m_prst));
      chk("puf_c",      64'(puf_c),      64'(m_c));
      if (m_valid) begin
        chk("resp_bit",  64'(resp_bit),  64'(m_bit));
        chk("resp_ones", 64'(resp_ones), 64'(m_resp_ones));
      end
    end
    if (puf_reset == 1'b0) low_cnt++;
  end

  // ---------------- ring output driver ----------------
  // 0: random toggling, 1: per-evaluation pattern, 2: drops one cycle before SAMPLE, 3: constant 1
  int        pmode = 3;
  logic [6:0] pat_v = '0;
  initial puf_out = 1'b0;

  always @(negedge clk) begin : drv
    int t;
    t = cyc - t0;
    case (pmode)
      0: if ($urandom_range(0, 3) == 0) puf_out = ~puf_out;
      1: puf_out = (t >= 0 && t / E < 7) ? pat_v[3'(t / E)] : 1'b0;
      2: puf_out = (t >= 0 && (t % E) >= E - 2) ? 1'b0 : 1'b1;
      default: puf_out = 1'b1;
    endcase
  end

  // ---------------- stimulus tasks (called and returning at a negedge) ----------------
  task automatic send_req(input logic [CW-1:0] chal);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_chal  = chal;
    for (int i = 0; i < 5000; i++) begin
      if (req_ready) begin
        t0 = cyc + 1;
        ok = 1;
        @(negedge clk);
        req_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_req: request never accepted, ready=%0b", req_ready);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (resp_valid) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_resp(input int hold);
    for (int i = 0; i < hold; i++) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int lat;
    logic [CW-1:0] ca, cb;
    rst = 1'b1; req_valid = 1'b0; req_chal = '0; resp_ready = 1'b0;
    req_valid2 = 1'b0; resp_ready2 = 1'b0; puf_out2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_puf_reset", 64'(puf_reset), 64'(1));
    chk("rst_puf_c",     64'(puf_c),     64'(0));
    chk("rst_resp_ones", 64'(resp_ones), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'(1));

    // Constant-1 ring: all evaluations vote 1.
    pmode = 3;
    low_cnt = 0;
    send_req(32'hDEADBEEF);
    chk("t1_puf_c", 64'(puf_c), 64'h0DEADBEEF);
    wait_resp(lat);
    chk("t1_latency", 64'(lat), 64'(484));
    chk("t1_ones", 64'(resp_ones), 64'(7));
    chk("t1_bit", 64'(resp_bit), 64'(1));
    chk("t1_low_cycles", 64'(low_cnt), 64'(455));
    finish_resp(0);

    // Pattern 1,0,1,0,0,1,0 then back-to-back pattern 1,1,0,1,0,0,1 with a held response.
    ca = $urandom; cb = $urandom;
    pmode = 1; pat_v = 7'b0100101;
    send_req(ca);
    wait_resp(lat);
    chk("t2_latency", 64'(lat), 64'(484));
    chk("t2_ones", 64'(resp_ones), 64'(3));
    chk("t2_bit", 64'(resp_bit), 64'(0));
    req_valid = 1'b1; req_chal = cb;
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", 64'(resp_valid), 64'(1));
      chk("hold_ones", 64'(resp_ones), 64'(3));
      chk("hold_bit", 64'(resp_bit), 64'(0));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("b2b_ready", 64'(req_ready), 64'(1));
    chk("b2b_valid_low", 64'(resp_valid), 64'(0));
    chk("b2b_old_chal", 64'(puf_c), 64'(ca));
    pat_v = 7'b1001011; t0 = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_new_chal", 64'(puf_c), 64'(cb));
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_resp(lat);
    chk("t3_latency", 64'(lat), 64'(484));
    chk("t3_ones", 64'(resp_ones), 64'(4));
    chk("t3_bit", 64'(resp_bit), 64'(1));
    finish_resp(2);

    // Ring drops to 0 one cycle before SAMPLE: the pre-toggle level must be sampled.
    pmode = 2;
    send_req($urandom);
    wait_resp(lat);
    chk("tog_ones", 64'(resp_ones), 64'(7));
    chk("tog_bit", 64'(resp_bit), 64'(1));
    finish_resp(3);

    // Reset pulse during the third SETTLE discards the transaction.
    pmode = 3;
    send_req(32'h12345678);
    while (cyc - t0 < 2 * E + int'(RST_CYC) + 5) @(negedge clk);
    chk("mid_puf_reset_low", 64'(puf_reset), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_puf_c", 64'(puf_c), 64'(0));
    chk("mid_puf_reset", 64'(puf_reset), 64'(1));
    chk("mid_valid", 64'(resp_valid), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("mid_ready", 64'(req_ready), 64'(1));
    send_req(32'hCAFEF00D);
    wait_resp(lat);
    chk("post_rst_latency", 64'(lat), 64'(484));
    chk("post_rst_ones", 64'(resp_ones), 64'(7));
    finish_resp(1);

    // Randomized transactions with a randomly toggling ring, checked by the model.
    pmode = 0;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_req($urandom);
      wait_resp(lat);
      chk("rand_latency", 64'(lat), 64'(LAT));
      finish_resp(int'($urandom_range(0, 4)));
    end

    // Minimal configuration: NEVAL=1, RST_CYC=1, SETTLE_CYC=2.
    for (int v = 1; v >= 0; v--) begin
      puf_out2 = 1'(v);
      repeat (3) @(negedge clk);
      chk("s_ready", 64'(req_ready2), 64'(1));
      req_valid2 = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      req_valid2 = 1'b0;
      lat = -1;
      for (int i = 0; i < 50; i++) begin
        if (resp_valid2) begin
          lat = cyc - t0;
          break;
        end
        @(negedge clk);
      end
      chk("s_latency", 64'(lat), 64'(5));
      chk("s_bit", 64'(resp_bit2), 64'(v));
      chk("s_ones", 64'(resp_ones2), 64'(v));
      resp_ready2 = 1'b1;
      @(negedge clk);
      resp_ready2 = 1'b0;
      chk("s_valid_low", 64'(resp_valid2), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nbr_ctrl.md
Name: nbr_ctrl

Overview:
Sequencing controller for the 32-bit bistable-ring PUF macro (NBR32). It accepts a challenge over a valid/ready handshake and drives the ring's C and RESET pins. It runs NEVAL reset/settle/sample evaluations of the same challenge and majority-votes the ring output, returning a response bit plus a ones-count over a second valid/ready handshake. It sits between the PUF macro and the on-chip challenge/response interface logic.

Parameters:
CW, 32, challenge width; must match the ring macro's C width
RST_CYC, 4, cycles PUF_RESET is held high per evaluation (>=1)
SETTLE_CYC, 64, cycles the ring runs free before sampling (>=2, covers synchronizer lag)
NEVAL, 7, evaluations per challenge (odd, >=1)
CNT_W, 8, width of ones counter and eval counter (NEVAL < 2^CNT_W)

Ports:
CLK  input  1  clock
RESET  input  1  synchronous active-high reset
REQ_VALID  input  1  challenge request valid
REQ_READY  output  1  controller can accept a challenge
REQ_CHAL  input  CW  challenge value
RESP_VALID  output  1  response available
RESP_READY  input  1  consumer accepts response
RESP_BIT  output  1  majority-voted PUF bit
RESP_ONES  output  CNT_W  number of evaluations that sampled 1
BUSY  output  1  transaction in progress (state != IDLE)
PUF_RESET  output  1  to ring RESET pin
PUF_C  output  CW  to ring C pins
PUF_OUT  input  1  ring OUT, asynchronous to CLK

Behaviour:
- One clock domain and one reset: the synchronous active-high RESET, sampled on the rising edge of CLK.
- Reset values: state IDLE, PUF_RESET=1, PUF_C=0, REQ_READY=0 during the reset cycle, RESP_VALID=0, RESP_BIT=0, RESP_ONES=0, BUSY=0, all counters 0, synchronizer flops 0.
- PUF_OUT passes through a 2-flop synchronizer (out_s). Every sampling decision uses out_s only.
- FSM states: IDLE, RST, SETTLE, SAMPLE, DONE.
- IDLE:
  - REQ_READY=1 and PUF_RESET=1.
  - On REQ_VALID&&REQ_READY at edge T0: latch REQ_CHAL into PUF_C, clear ones_cnt and eval_cnt, go to RST.
- RST:
  - PUF_RESET=1 for exactly RST_CYC cycles, then go to SETTLE.
- SETTLE:
  - PUF_RESET=0 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - PUF_RESET=0. ones_cnt += out_s; eval_cnt += 1.
  - If the incremented eval_cnt == NEVAL, go to DONE; otherwise go to RST.
- DONE:
  - PUF_RESET=1 and RESP_VALID=1.
  - RESP_ONES=ones_cnt. RESP_BIT = (2*ones_cnt > NEVAL); compare at CNT_W+1 bits, no overflow.
  - Outputs stay stable until RESP_VALID&&RESP_READY, then go to IDLE.
- Timing:
  - Per-evaluation period E = RST_CYC+SETTLE_CYC+1 cycles.
  - RESP_VALID first rises NEVAL*E+1 edges after T0. With defaults: E=69, so RESP_VALID rises at T0+484.
- PUF_C is constant from T0 until the next accept, including while in IDLE; the ring stays configured for the last challenge.
- REQ_READY=0 in every state except IDLE; requests presented while busy are neither accepted nor lost, they simply wait.
- Back-to-back: a response handshake moves the FSM to IDLE. The earliest next accept is the following edge, so there is one idle cycle minimum between transactions.
- RESP_READY asserted while RESP_VALID=0 has no effect. RESP_VALID never drops without a handshake, except on RESET.
- RESET mid-transaction: the FSM goes to IDLE on that edge, any in-flight or pending response is discarded, and all outputs return to their reset values.
- BUSY = (state != IDLE).
- Ring metastability: the synchronizer is the only path from PUF_OUT into logic. No combinational path exists from PUF_OUT to any output.

Test Plan:
- Ring model OUT=1 constant, defaults, REQ_CHAL=0xDEADBEEF -> PUF_C=0xDEADBEEF from T0+1. Seven PUF_RESET low pulses of 65 cycles each. RESP_VALID at T0+484 with RESP_BIT=1, RESP_ONES=7.
- Ring model OUT pattern 1,0,1,0,0,1,0 across evals -> RESP_ONES=3, RESP_BIT=0. Pattern 1,1,0,1,0,0,1 -> RESP_ONES=4, RESP_BIT=1.
- Hold RESP_READY=0 for 20 cycles after RESP_VALID -> RESP_VALID, RESP_BIT and RESP_ONES stay stable, REQ_READY=0. Second REQ_VALID is held until the handshake and accepted exactly 1 cycle later with its new challenge.
- Assert RESET for 1 cycle during the 3rd SETTLE -> next cycle state IDLE, PUF_RESET=1, PUF_C=0, RESP_VALID=0, REQ_READY=1. A subsequent challenge completes with full NEVAL count.
- OUT toggles 1 cycle before SAMPLE -> sampled value is the pre-toggle level (2-flop lag), confirming no sample skew.
- NEVAL=1, RST_CYC=1, SETTLE_CYC=2 -> RESP_VALID at T0+5. RESP_BIT equals the sampled out_s, and RESP_ONES is 0 or 1 accordingly.
